// File: rtl/lpddr3_dm_lane_tx_sched.sv
`timescale 1ns/1ps
// lpddr3_dm_lane_tx_sched
// Write-path scheduler feeding the LPDDR3 DM lane IOD. Each accepted
// data-mask word is timestamped with (now + WL) and issued in FIFO order
// when the free-running 5-bit cycle counter reaches that stamp.
// The bursts are then shaped into TX_DATA_0, OE_DATA_0 and ODT_EN_0.
//
// Ports
//   FAB_CLK     fabric clock, rising edge
//   ARST_N      asynchronous active-low reset
//   CFG_WL      write latency (legal 2..WL_MAX), sampled while idle
//   WR_VALID    burst request
//   WR_READY    burst accepted on an edge where WR_VALID && WR_READY
//   WR_MASK     DM bits for beats 0..7 (bit0 = first beat)
//   TX_DATA_0   DM serial word to IOD
//   OE_DATA_0   output enable per HS_IO_CLK period (bit0 = earliest)
//   ODT_EN_0    on-die termination enable
//   BUSY        queue non-empty, ODT window open or postamble pending
//   ERR_WL      sticky: write attempted with an illegal latency
//   STAT_BURSTS issued-burst counter (LPDDR3_DM_TX_STATS_EN only)
//   STAT_MASKED issued bursts with nonzero mask (LPDDR3_DM_TX_STATS_EN only)
//
// Optional feature macro: LPDDR3_DM_TX_STATS_EN
module lpddr3_dm_lane_tx_sched #(
  parameter int unsigned WL_MAX    = 16,
  parameter int unsigned QDEPTH    = 16,
  parameter int unsigned ODT_LEAD  = 1,
  parameter int unsigned ODT_TRAIL = 1
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic [4:0] CFG_WL,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [7:0] WR_MASK,
  output logic [7:0] TX_DATA_0,
  output logic [3:0] OE_DATA_0,
  output logic       ODT_EN_0,
  output logic       BUSY,
  output logic       ERR_WL
`ifdef LPDDR3_DM_TX_STATS_EN
  ,
  output logic [15:0] STAT_BURSTS,
  output logic [15:0] STAT_MASKED
`endif
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned TW = (ODT_TRAIL > 0) ? ODT_TRAIL : 1;
  localparam logic [4:0]  C_WLMAX = 5'(WL_MAX);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(QDEPTH);

  logic [4:0]    r_ts;
  logic [4:0]    r_wl;
  logic          r_live;
  logic [7:0]    r_qmask [QDEPTH];
  logic [4:0]    r_qts   [QDEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          r_burst;
  logic [TW-1:0] r_hist;
  logic [7:0]    r_tx;
  logic [3:0]    r_oe;
  logic          r_odt;
  logic          r_err;

  logic          w_wl_ok;
  logic          w_full;
  logic          w_pop;
  logic          w_ready;
  logic          w_push;
  logic          w_pre;
  logic          w_lead;
  logic          w_trail;
  logic          w_busy;
  logic [7:0]    w_tx_nxt;
  logic [3:0]    w_oe_nxt;
  logic          w_odt_nxt;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (32'(p) == QDEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign w_wl_ok = (r_wl >= 5'd2) && (r_wl <= C_WLMAX);
  assign w_full  = (r_cnt == C_DEPTH);
  assign w_pop   = (r_cnt != '0) && (r_qts[r_rd] == r_ts);
  // A pop on this edge frees a slot, so a full queue can still accept.
  assign w_ready = r_live && w_wl_ok && (!w_full || w_pop);
  assign w_push  = WR_VALID && w_ready;

  // Look ahead through the queue: preamble if a burst issues on the next
  // edge, ODT lead if one issues within ODT_LEAD edges. An entry being
  // accepted this edge is included so an oversized lead clips to accept.
  always_comb begin
    logic [4:0]  v_dist;
    int unsigned v_k;
    w_pre  = 1'b0;
    w_lead = 1'b0;
    v_dist = '0;
    v_k    = 0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      v_k    = (32'(r_rd) + i) % QDEPTH;
      v_dist = r_qts[v_k[AW-1:0]] - r_ts;
      if (i < 32'(r_cnt)) begin
        if (v_dist == 5'd1) w_pre = 1'b1;
        if ((v_dist != 5'd0) && (32'(v_dist) <= ODT_LEAD)) w_lead = 1'b1;
      end
    end
    if (w_push && (32'(r_wl) <= ODT_LEAD)) w_lead = 1'b1;
  end

  assign w_trail   = (ODT_TRAIL > 0) ? (|r_hist) : 1'b0;
  assign w_odt_nxt = w_pop || w_lead || w_trail;
  assign w_oe_nxt  = w_pop ? 4'b1111 : {w_pre, 2'b00, r_burst};
  assign w_tx_nxt  = w_pop ? r_qmask[r_rd] : '0;
  assign w_busy    = (r_cnt != '0) || r_odt || r_burst;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_ts    <= '0;
      r_wl    <= '0;
      r_live  <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_burst <= 1'b0;
      r_hist  <= '0;
      r_tx    <= '0;
      r_oe    <= '0;
      r_odt   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_ts   <= r_ts + 5'd1;
      if (!w_busy) r_wl <= CFG_WL;
      if (WR_VALID && r_live && !w_wl_ok) r_err <= 1'b1;
      if (w_push) r_wr <= f_inc(r_wr);
      if (w_pop)  r_rd <= f_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_burst <= w_pop;
      r_hist  <= TW'({r_hist, w_pop});
      r_tx    <= w_tx_nxt;
      r_oe    <= w_oe_nxt;
      r_odt   <= w_odt_nxt;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (w_push) begin
      r_qmask[r_wr] <= WR_MASK;
      r_qts[r_wr]   <= r_ts + r_wl;
    end
  end

`ifdef LPDDR3_DM_TX_STATS_EN
  logic [15:0] r_stat_b;
  logic [15:0] r_stat_m;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_stat_b <= '0;
      r_stat_m <= '0;
    end else if (w_pop) begin
      if (r_stat_b != '1) r_stat_b <= r_stat_b + 16'd1;
      if ((r_qmask[r_rd] != '0) && (r_stat_m != '1)) r_stat_m <= r_stat_m + 16'd1;
    end
  end

  assign STAT_BURSTS = r_stat_b;
  assign STAT_MASKED = r_stat_m;
`endif

  assign WR_READY  = w_ready;
  assign TX_DATA_0 = r_tx;
  assign OE_DATA_0 = r_oe;
  assign ODT_EN_0  = r_odt;
  assign BUSY      = w_busy;
  assign ERR_WL    = r_err;

endmodule

// File: tb/tb_lpddr3_dm_lane_tx_sched.sv
`timescale 1ns/1ps
module tb_lpddr3_dm_lane_tx_sched;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic [4:0] CFG_WL  = 5'd4;
  logic       WR_VALID = 1'b0;
  logic       WR_READY;
  logic [7:0] WR_MASK = 8'h00;
  logic [7:0] TX_DATA_0;
  logic [3:0] OE_DATA_0;
  logic       ODT_EN_0;
  logic       BUSY;
  logic       ERR_WL;
`ifdef LPDDR3_DM_TX_STATS_EN
  logic [15:0] STAT_BURSTS;
  logic [15:0] STAT_MASKED;
`endif

  int total = 0;
  int bad   = 0;

  lpddr3_dm_lane_tx_sched #(
    .WL_MAX(16), .QDEPTH(16), .ODT_LEAD(1), .ODT_TRAIL(1)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .CFG_WL(CFG_WL),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_MASK(WR_MASK),
    .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0), .ODT_EN_0(ODT_EN_0),
    .BUSY(BUSY), .ERR_WL(ERR_WL)
`ifdef LPDDR3_DM_TX_STATS_EN
    , .STAT_BURSTS(STAT_BURSTS), .STAT_MASKED(STAT_MASKED)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] wl;
    logic       vld;
    logic [7:0] mask;
    logic [7:0] tx;
    logic [3:0] oe;
    logic       odt;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] wl, input logic vld, input logic [7:0] mask,
                              input logic [7:0] tx, input logic [3:0] oe, input logic odt,
                              input logic busy);
    vec_t v;
    v.wl = wl; v.vld = vld; v.mask = mask; v.tx = tx; v.oe = oe; v.odt = odt; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, then sample outputs on the following falling edge.
  task automatic step();
    @(posedge FAB_CLK);
    @(negedge FAB_CLK);
  endtask

  initial begin
    int n_burst;

    // ---- table: WL=4 single, WL=6 x4 back-to-back, WL=3 with one-cycle gap
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd4, 1, 8'hA5, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b1000, 1, 1));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'hA5, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b0001, 1, 1));
    tbl.push_back(mk(5'd4, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd6, 1, 8'h01, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd6, 1, 8'h02, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd6, 1, 8'h04, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd6, 1, 8'h08, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h00, 4'b1000, 1, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h01, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h02, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h04, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h08, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h00, 4'b0001, 1, 1));
    tbl.push_back(mk(5'd6, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h00, 4'b0000, 0, 0));
    tbl.push_back(mk(5'd3, 1, 8'h11, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h00, 4'b0000, 0, 1));
    tbl.push_back(mk(5'd3, 1, 8'h22, 8'h00, 4'b1000, 1, 1));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h11, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h00, 4'b1001, 1, 1));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h22, 4'b1111, 1, 1));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h00, 4'b0001, 1, 1));
    tbl.push_back(mk(5'd3, 0, 8'h00, 8'h00, 4'b0000, 0, 0));

    // ---- reset state
    repeat (3) @(negedge FAB_CLK);
    chk("rst_tx",    32'(TX_DATA_0), 32'h0);
    chk("rst_oe",    32'(OE_DATA_0), 32'h0);
    chk("rst_odt",   32'(ODT_EN_0),  32'h0);
    chk("rst_ready", 32'(WR_READY),  32'h0);
    chk("rst_busy",  32'(BUSY),      32'h0);
    chk("rst_err",   32'(ERR_WL),    32'h0);
    ARST_N = 1'b1;

    // ---- table-driven vectors
    foreach (tbl[i]) begin
      CFG_WL = tbl[i].wl; WR_VALID = tbl[i].vld; WR_MASK = tbl[i].mask;
      step();
      chk($sformatf("tbl%0d_tx", i),    32'(TX_DATA_0), 32'(tbl[i].tx));
      chk($sformatf("tbl%0d_oe", i),    32'(OE_DATA_0), 32'(tbl[i].oe));
      chk($sformatf("tbl%0d_odt", i),   32'(ODT_EN_0),  32'(tbl[i].odt));
      chk($sformatf("tbl%0d_busy", i),  32'(BUSY),      32'(tbl[i].busy));
      chk($sformatf("tbl%0d_ready", i), 32'(WR_READY),  32'h1);
    end

    // ---- WL=16, 40 back-to-back accepts, queue depth 16
    CFG_WL = 5'd16; WR_VALID = 1'b0;
    step(); step();
    n_burst = 0;
    for (int k = 0; k < 60; k++) begin
      WR_VALID = (k < 40);
      WR_MASK  = 8'(k + 1);
      step();
      if (k < 40) chk($sformatf("wl16_ready%0d", k), 32'(WR_READY), 32'h1);
      chk($sformatf("wl16_tx%0d", k), 32'(TX_DATA_0),
          (k >= 16 && k < 56) ? 32'(k - 15) : 32'h0);
      if (OE_DATA_0 == 4'b1111) n_burst++;
    end
    chk("wl16_bursts", 32'(n_burst), 32'd40);
    chk("wl16_busy_end", 32'(BUSY), 32'h0);
`ifdef LPDDR3_DM_TX_STATS_EN
    chk("stat_bursts", 32'(STAT_BURSTS), 32'd47);
    chk("stat_masked", 32'(STAT_MASKED), 32'd47);
`endif

    // ---- illegal WL=1, then recover to WL=4 with ERR_WL sticky
    CFG_WL = 5'd1; WR_VALID = 1'b0;
    step(); step();
    chk("wl1_ready_idle", 32'(WR_READY), 32'h0);
    chk("wl1_err_idle",   32'(ERR_WL),   32'h0);
    WR_VALID = 1'b1; WR_MASK = 8'h3C;
    step();
    chk("wl1_err_set", 32'(ERR_WL),   32'h1);
    chk("wl1_ready",   32'(WR_READY), 32'h0);
    step();
    chk("wl1_tx_none", 32'(TX_DATA_0), 32'h0);
    CFG_WL = 5'd4;
    step();
    chk("wl4_ready", 32'(WR_READY), 32'h1);
    step();
    WR_VALID = 1'b0;
    step(); step(); step();
    chk("wl4_pre_oe", 32'(OE_DATA_0), 32'b1000);
    step();
    chk("wl4_tx",        32'(TX_DATA_0), 32'h3C);
    chk("wl4_err_stick", 32'(ERR_WL),    32'h1);
    step(); step(); step();

    // ---- reset mid-burst with three entries still queued
    CFG_WL = 5'd6;
    step(); step();
    WR_VALID = 1'b1;
    WR_MASK = 8'h5A; step();
    WR_MASK = 8'hC3; step();
    WR_MASK = 8'h7E; step();
    WR_MASK = 8'h81; step();
    WR_VALID = 1'b0;
    step(); step(); step();
    chk("mid_tx",  32'(TX_DATA_0), 32'h5A);
    chk("mid_oe",  32'(OE_DATA_0), 32'hF);
    chk("mid_err", 32'(ERR_WL),    32'h1);
    #2 ARST_N = 1'b0;
    #1;
    chk("arst_tx",    32'(TX_DATA_0), 32'h0);
    chk("arst_oe",    32'(OE_DATA_0), 32'h0);
    chk("arst_odt",   32'(ODT_EN_0),  32'h0);
    chk("arst_busy",  32'(BUSY),      32'h0);
    chk("arst_ready", 32'(WR_READY),  32'h0);
    chk("arst_err",   32'(ERR_WL),    32'h0);
    step(); step();
    ARST_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("post_tx%0d", k), 32'(TX_DATA_0), 32'h0);
      chk($sformatf("post_oe%0d", k), 32'(OE_DATA_0), 32'h0);
    end
    chk("post_busy",  32'(BUSY),     32'h0);
    chk("post_ready", 32'(WR_READY), 32'h1);
    chk("post_err",   32'(ERR_WL),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
